dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// =============================================================================
// dmem_arbiter : two-requester data-memory arbiter with access checking and
//                load formatting. Optional DMEM_ARBITER_RR_EN: round-robin ties.
// Revision     : 1.0
// =============================================================================
module dmem_arbiter #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req_valid_0,
  output logic        req_ready_0,
  input  logic        req_we_0,
  input  logic [31:0] req_addr_0,
  input  logic [31:0] req_wdata_0,
  input  logic [2:0]  req_func3_0,
  output logic        resp_valid_0,
  output logic [31:0] resp_rdata_0,
  output logic        resp_err_0,

  input  logic        req_valid_1,
  output logic        req_ready_1,
  input  logic        req_we_1,
  input  logic [31:0] req_addr_1,
  input  logic [31:0] req_wdata_1,
  input  logic [2:0]  req_func3_1,
  output logic        resp_valid_1,
  output logic [31:0] resp_rdata_1,
  output logic        resp_err_1,

  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_func3,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] c_depth = 33'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_func3;
  logic        r_we;
  logic        r_owner;
  logic        r_strobe;
  logic        r_rvalid;
  logic        r_rerr;
  logic [31:0] r_rdata;

  logic        w_idle;
  logic        w_sel1;
  logic        w_accept;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [2:0]  w_func3;
  logic [2:0]  w_size;
  logic [32:0] w_last;
  logic        w_illegal;
  logic        w_strobe;

`ifdef DMEM_ARBITER_RR_EN
  // r_prio names the requester that wins the next tie.
  logic        r_prio;
  assign w_sel1 = req_valid_1 && (!req_valid_0 || r_prio);
`else
  assign w_sel1 = req_valid_1 && !req_valid_0;
`endif

  assign w_idle      = (r_state == ST_IDLE) && !rst;
  assign req_ready_0 = w_idle && req_valid_0 && !w_sel1;
  assign req_ready_1 = w_idle && w_sel1;
  assign w_accept    = req_ready_0 || req_ready_1;

  assign w_we    = w_sel1 ? req_we_1    : req_we_0;
  assign w_addr  = w_sel1 ? req_addr_1  : req_addr_0;
  assign w_wdata = w_sel1 ? req_wdata_1 : req_wdata_0;
  assign w_func3 = w_sel1 ? req_func3_1 : req_func3_0;

  // Legality of the request currently presented by the granted requester.
  always_comb begin
    w_size = 3'd4;
    case (w_func3[1:0])
      2'b00:   w_size = 3'd1;
      2'b01:   w_size = 3'd2;
      default: w_size = 3'd4;
    endcase
    // 33-bit sum so an address near 2^32 cannot wrap past the range check.
    w_last    = {1'b0, w_addr} + 33'(w_size) - 33'd1;
    w_illegal = 1'b0;
    if (w_func3 == 3'b011 || w_func3[2:1] == 2'b11) w_illegal = 1'b1;
    if (w_we && w_func3[2])                         w_illegal = 1'b1;
    if (w_func3[1:0] == 2'b01 && w_addr[0])         w_illegal = 1'b1;
    if (w_func3[1:0] == 2'b10 && w_addr[1:0] != 2'b00) w_illegal = 1'b1;
    if (w_last >= c_depth)                          w_illegal = 1'b1;
  end

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  fmt_load = {{24{d[7]}}, d[7:0]};
      3'b001:  fmt_load = {{16{d[15]}}, d[15:0]};
      3'b100:  fmt_load = {24'd0, d[7:0]};
      3'b101:  fmt_load = {16'd0, d[15:0]};
      default: fmt_load = d;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_func3  <= 3'd0;
      r_we     <= 1'b0;
      r_owner  <= 1'b0;
      r_strobe <= 1'b0;
      r_rvalid <= 1'b0;
      r_rerr   <= 1'b0;
      r_rdata  <= 32'd0;
`ifdef DMEM_ARBITER_RR_EN
      r_prio   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_func3 <= w_func3;
            r_we    <= w_we;
            r_owner <= w_sel1;
`ifdef DMEM_ARBITER_RR_EN
            r_prio  <= !w_sel1;
`endif
            if (w_illegal) begin
              r_state  <= ST_RESP;
              r_rvalid <= 1'b1;
              r_rerr   <= 1'b1;
              r_rdata  <= 32'd0;
            end else begin
              r_state  <= ST_ACCESS;
              r_strobe <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          r_state  <= ST_RESP;
          r_strobe <= 1'b0;
          r_rvalid <= 1'b1;
          r_rerr   <= 1'b0;
          r_rdata  <= r_we ? 32'd0 : fmt_load(r_func3, mem_rdata);
        end
        ST_RESP: begin
          r_state  <= ST_IDLE;
          r_rvalid <= 1'b0;
          r_rerr   <= 1'b0;
          r_rdata  <= 32'd0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_strobe <= 1'b0;
          r_rvalid <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are qualified by !rst so nothing leaks during the reset cycle itself.
  assign w_strobe  = r_strobe && !rst;
  assign mem_read  = w_strobe && !r_we;
  assign mem_write = w_strobe && r_we;
  assign mem_addr  = w_strobe ? r_addr  : 32'd0;
  assign mem_wdata = w_strobe ? r_wdata : 32'd0;
  assign mem_func3 = w_strobe ? r_func3 : 3'd0;

  assign resp_valid_0 = r_rvalid && !r_owner && !rst;
  assign resp_valid_1 = r_rvalid &&  r_owner && !rst;
  assign resp_rdata_0 = resp_valid_0 ? r_rdata : 32'd0;
  assign resp_rdata_1 = resp_valid_1 ? r_rdata : 32'd0;
  assign resp_err_0   = resp_valid_0 && r_rerr;
  assign resp_err_1   = resp_valid_1 && r_rerr;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// tb_dmem_arbiter : directed transactions checked against a transaction-level
// model every cycle, plus literal expectations per transaction.
module tb_dmem_arbiter;

  localparam int DEPTH = 1024;
`ifdef DMEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_0 = 0, req_we_0 = 0, req_valid_1 = 0, req_we_1 = 0;
  logic [31:0] req_addr_0 = 0, req_wdata_0 = 0, req_addr_1 = 0, req_wdata_1 = 0;
  logic [2:0]  req_func3_0 = 0, req_func3_1 = 0;
  logic        req_ready_0, req_ready_1;
  logic        resp_valid_0, resp_err_0, resp_valid_1, resp_err_1;
  logic [31:0] resp_rdata_0, resp_rdata_1;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_func3;
  logic        mem_read, mem_write;
  logic [31:0] mem_rdata = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
    .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0), .req_func3_0(req_func3_0),
    .resp_valid_0(resp_valid_0), .resp_rdata_0(resp_rdata_0), .resp_err_0(resp_err_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
    .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1), .req_func3_1(req_func3_1),
    .resp_valid_1(resp_valid_1), .resp_rdata_1(resp_rdata_1), .resp_err_1(resp_err_1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_func3(mem_func3),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h, want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [31:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = d[7:0];
    h = d[15:0];
    case (f3)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return 32'(d[7:0]);
      3'b101:  return 32'(d[15:0]);
      default: return d;
    endcase
  endfunction

  function automatic bit illegal(input bit we, input logic [31:0] a, input logic [2:0] f3);
    longint size;
    if (f3 inside {3'b011, 3'b110, 3'b111}) return 1'b1;
    if (we && !(f3 inside {3'b000, 3'b001, 3'b010})) return 1'b1;
    size = longint'(1) << f3[1:0];
    if (longint'(a) % size != 0) return 1'b1;
    if (longint'(a) + size - 1 >= longint'(DEPTH)) return 1'b1;
    return 1'b0;
  endfunction

  // Transaction model: at most one request in flight, scheduled by cycle number.
  int          m_free = 0, m_tstrobe = -1, m_tresp = -1;
  bit          m_prio = 0, m_own = 0, m_we = 0, m_err = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
  logic [2:0]  m_f3 = 0;

  always @(negedge clk) begin
    bit e_idle, e_sel1, e_r0, e_r1, e_s, e_rv, e_v0, e_v1;
    e_idle = !rst && (cyc >= m_free);
    e_sel1 = req_valid_1 && (!req_valid_0 || (RR && m_prio));
    e_r0   = e_idle && req_valid_0 && !e_sel1;
    e_r1   = e_idle && e_sel1;
    e_s    = !rst && (cyc == m_tstrobe);
    e_rv   = !rst && (cyc == m_tresp);
    if (e_s && !m_we) m_rdata = fmt(m_f3, mem_rdata);
    e_v0 = e_rv && !m_own;
    e_v1 = e_rv && m_own;
    chk("req_ready_0", 32'(req_ready_0), 32'(e_r0));
    chk("req_ready_1", 32'(req_ready_1), 32'(e_r1));
    chk("mem_read",    32'(mem_read),    32'(e_s && !m_we));
    chk("mem_write",   32'(mem_write),   32'(e_s && m_we));
    chk("mem_addr",    mem_addr,  e_s ? m_addr  : 32'd0);
    chk("mem_wdata",   mem_wdata, e_s ? m_wdata : 32'd0);
    chk("mem_func3",   32'(mem_func3), e_s ? 32'(m_f3) : 32'd0);
    chk("resp_valid_0", 32'(resp_valid_0), 32'(e_v0));
    chk("resp_valid_1", 32'(resp_valid_1), 32'(e_v1));
    chk("resp_rdata_0", resp_rdata_0, e_v0 ? m_rdata : 32'd0);
    chk("resp_rdata_1", resp_rdata_1, e_v1 ? m_rdata : 32'd0);
    chk("resp_err_0",  32'(resp_err_0), 32'(e_v0 && m_err));
    chk("resp_err_1",  32'(resp_err_1), 32'(e_v1 && m_err));
    if (rst) begin
      m_free = cyc + 1; m_tstrobe = -1; m_tresp = -1; m_prio = 0;
    end else if (e_r0 || e_r1) begin
      m_own   = e_r1;
      m_we    = e_r1 ? req_we_1    : req_we_0;
      m_addr  = e_r1 ? req_addr_1  : req_addr_0;
      m_wdata = e_r1 ? req_wdata_1 : req_wdata_0;
      m_f3    = e_r1 ? req_func3_1 : req_func3_0;
      m_prio  = !e_r1;
      m_err   = illegal(m_we, m_addr, m_f3);
      m_rdata = 32'd0;
      if (m_err) begin
        m_tresp = cyc + 1; m_free = cyc + 2;
      end else begin
        m_tstrobe = cyc + 1; m_tresp = cyc + 2; m_free = cyc + 3;
      end
    end
  end

  int          last_wr_cyc = -1;
  logic [31:0] last_wr_addr = 0;
  always @(negedge clk) if (mem_write) begin
    last_wr_cyc  = cyc;
    last_wr_addr = mem_addr;
  end

  typedef struct {
    bit          n;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] rdat;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  task automatic send(input vec_t v, input int idx);
    int acc, rsp;
    logic [31:0] rd;
    logic er;
    string tag;
    tag = $sformatf("v%0d", idx);
    mem_rdata = v.rdat;
    if (v.n) begin
      req_valid_1 = 1; req_we_1 = v.we; req_addr_1 = v.addr; req_wdata_1 = v.wdata; req_func3_1 = v.f3;
    end else begin
      req_valid_0 = 1; req_we_0 = v.we; req_addr_0 = v.addr; req_wdata_0 = v.wdata; req_func3_0 = v.f3;
    end
    acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      @(negedge clk);
      if (v.n ? req_ready_1 : req_ready_0) acc = cyc;
      @(posedge clk); #1;
    end
    req_valid_0 = 0; req_valid_1 = 0;
    chk({tag, "_accepted"}, 32'(acc >= 0), 32'd1);
    rsp = -1; rd = 0; er = 0;
    for (int i = 0; i < 10 && rsp < 0; i++) begin
      @(negedge clk);
      if (v.n ? resp_valid_1 : resp_valid_0) begin
        rsp = cyc;
        rd  = v.n ? resp_rdata_1 : resp_rdata_0;
        er  = v.n ? resp_err_1   : resp_err_0;
      end
    end
    chk({tag, "_latency"}, 32'(rsp - acc), v.exp_err ? 32'd1 : 32'd2);
    chk({tag, "_rdata"}, rd, v.exp_rdata);
    chk({tag, "_err"}, 32'(er), 32'(v.exp_err));
    if (v.we && !v.exp_err) begin
      chk({tag, "_wr_cycle"}, 32'(last_wr_cyc - acc), 32'd1);
      chk({tag, "_wr_addr"}, last_wr_addr, v.addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
  endtask

  vec_t vecs[12];
  int   grants[4];
  int   ng;

  initial begin
    //            n  we addr          wdata          f3      rdat           exp_rdata      err
    vecs[0]  = '{0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 32'h0,         32'h0,         0};
    vecs[1]  = '{0, 0, 32'h0000_0013, 32'h0,         3'b000, 32'h0000_00EF, 32'hFFFF_FFEF, 0};
    vecs[2]  = '{0, 0, 32'h0000_0013, 32'h0,         3'b100, 32'h0000_00EF, 32'h0000_00EF, 0};
    vecs[3]  = '{1, 0, 32'h0000_0002, 32'h0,         3'b010, 32'h1111_1111, 32'h0,         1};
    vecs[4]  = '{0, 0, 32'h0000_03FE, 32'h0,         3'b010, 32'h1111_1111, 32'h0,         1};
    vecs[5]  = '{1, 0, 32'h0000_0006, 32'h0,         3'b001, 32'h0000_8001, 32'hFFFF_8001, 0};
    vecs[6]  = '{1, 0, 32'h0000_0006, 32'h0,         3'b101, 32'h0000_8001, 32'h0000_8001, 0};
    vecs[7]  = '{0, 0, 32'h0000_03FC, 32'h0,         3'b010, 32'h1234_5678, 32'h1234_5678, 0};
    vecs[8]  = '{0, 0, 32'h0000_0400, 32'h0,         3'b000, 32'h0000_0055, 32'h0,         1};
    vecs[9]  = '{1, 1, 32'h0000_0008, 32'h0000_00AA, 3'b100, 32'h0,         32'h0,         1};
    vecs[10] = '{0, 0, 32'h0000_0020, 32'h0,         3'b011, 32'h0,         32'h0,         1};
    vecs[11] = '{1, 1, 32'h0000_03FE, 32'h0000_BEEF, 3'b001, 32'h0,         32'h0,         0};

    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    foreach (vecs[i]) send(vecs[i], i);

    // Arbitration with both requesters asserting continuously.
    do_reset();
    mem_rdata = 32'hCAFE_F00D;
    req_we_0 = 0; req_addr_0 = 32'h20; req_func3_0 = 3'b010;
    req_we_1 = 0; req_addr_1 = 32'h24; req_func3_1 = 3'b010;
    req_valid_0 = 1; req_valid_1 = 1;
    ng = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      @(negedge clk);
      if (req_ready_0) begin grants[ng] = 0; ng++; end
      else if (req_ready_1) begin grants[ng] = 1; ng++; end
      @(posedge clk); #1;
    end
    req_valid_0 = 0; req_valid_1 = 0;
    chk("grant_count", 32'(ng), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("grant%0d", i), 32'(grants[i]), (RR && (i % 2 == 1)) ? 32'd1 : 32'd0);
    repeat (4) @(posedge clk);
    #1;

    // Reset while the accepted request is in its access cycle.
    req_we_0 = 0; req_addr_0 = 32'h40; req_func3_0 = 3'b010; req_valid_0 = 1;
    ng = -1;
    for (int i = 0; i < 10 && ng < 0; i++) begin
      @(negedge clk);
      if (req_ready_0) ng = cyc;
      @(posedge clk); #1;
    end
    req_valid_0 = 0;
    rst = 1;
    @(negedge clk);
    chk("rst_access_read", 32'(mem_read), 32'd0);
    chk("rst_access_resp0", 32'(resp_valid_0), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    req_we_0 = 0; req_addr_0 = 32'h1; req_func3_0 = 3'b000; req_valid_0 = 1;
    mem_rdata = 32'h0000_0080;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready_0), 32'd1);
    chk("no_resp_after_rst", 32'(resp_valid_0 | resp_valid_1), 32'd0);
    @(posedge clk); #1;
    req_valid_0 = 0;
    repeat (5) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
